// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states and default frame constants
// used by the baud generator, receiver and transmitter.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver output bundle: byte, strobes and busy flag.
// The receiver drives it as master, the consumer reads it as slave.
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS
);

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 framing_error;
    logic                 busy;

    modport master (
        output rx_data,
        output rx_valid,
        output framing_error,
        output busy
    );

    modport slave (
        input rx_data,
        input rx_valid,
        input framing_error,
        input busy
    );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, with a
// configurable reset value so idle-high lines come up idle.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling 8N1 UART receiver driven by the baud generator's
// sample_pulse strobe; reports bytes and framing errors as pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_pulse,
    input  logic rx,
    uart_rx_if.master io
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state;
    logic [TW-1:0]        tick;
    logic [BW-1:0]        bitn;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 busy_q;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tick    <= '0;
            bitn    <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            if (sample_pulse) begin
                unique case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state  <= START;
                            tick   <= '0;
                            busy_q <= 1'b1;
                        end
                    end
                    START: begin
                        if (tick == TICK_MID) begin
                            // re-check the line at mid start bit to reject glitches
                            if (!rx_s) begin
                                state <= DATA;
                                tick  <= '0;
                                bitn  <= '0;
                            end else begin
                                state  <= IDLE;
                                busy_q <= 1'b0;
                            end
                        end else begin
                            tick <= tick + 1'b1;
                        end
                    end
                    DATA: begin
                        tick <= tick + 1'b1;
                        if (tick == TICK_LAST) begin
                            shreg <= DATA_BITS'({rx_s, shreg} >> 1);
                            if (bitn == BIT_LAST) begin
                                state <= STOP;
                            end else begin
                                bitn <= bitn + 1'b1;
                            end
                        end
                    end
                    STOP: begin
                        tick <= tick + 1'b1;
                        if (tick == TICK_LAST) begin
                            if (rx_s) begin
                                data_q  <= shreg;
                                valid_q <= 1'b1;
                                state   <= IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                ferr_q <= 1'b1;
                                state  <= BREAK;
                            end
                        end
                    end
                    BREAK: begin
                        // a held-low line must return high before rearming
                        if (rx_s) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign io.rx_data       = data_q;
    assign io.rx_valid      = valid_q;
    assign io.framing_error = ferr_q;
    assign io.busy          = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level model plus directed scenarios.
module tb_uart_rx;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sample_pulse = 1'b0;
    logic rx = 1'b1;
    logic gate = 1'b1;

    int cyc = 0;
    int tick_cnt = 0;
    int checks = 0;
    int errors = 0;
    int stop_start = 0;

    typedef struct {
        bit         fe;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];
    int valid_times[$];
    logic [7:0] last_good = 8'h00;
    logic prev_v = 1'b0;
    logic prev_fe = 1'b0;

    uart_rx_if #(.DATA_BITS(8)) u_if ();

    uart_rx dut (
        .clk          (clk),
        .reset        (reset),
        .sample_pulse (sample_pulse),
        .rx           (rx),
        .io           (u_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cyc %0d",
                     name, act, exp, cyc);
        end
    endtask

    // one sample_pulse every 4 clk while gate is open
    initial begin
        forever begin
            repeat (3) @(negedge clk);
            sample_pulse = gate;
            if (gate) tick_cnt++;
            @(negedge clk);
            sample_pulse = 1'b0;
        end
    end

    task automatic wait_ticks(input int n);
        int t;
        t = tick_cnt + n;
        while (tick_cnt < t) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        ev_t e;
        e.fe = !stop;
        e.data = d;
        exp_q.push_back(e);
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_ticks(16);
        end
        stop_start = cyc;
        rx = stop;
        wait_ticks(16);
    endtask

    // compare process: checks pulses against the frame model every cycle
    initial begin
        ev_t e;
        int lat;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("reset_outputs",
                    32'({u_if.rx_data, u_if.rx_valid,
                         u_if.framing_error, u_if.busy}), 32'h0);
                last_good = 8'h00;
            end else begin
                if (u_if.rx_valid && prev_v)
                    chk("valid_width", 32'(u_if.rx_valid), 32'h0);
                if (u_if.framing_error && prev_fe)
                    chk("ferr_width", 32'(u_if.framing_error), 32'h0);
                if (u_if.rx_valid || u_if.framing_error) begin
                    chk("exclusive",
                        32'(u_if.rx_valid & u_if.framing_error), 32'h0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_event",
                            32'({u_if.rx_valid, u_if.framing_error}), 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("event_kind", 32'(u_if.framing_error), 32'(e.fe));
                        lat = cyc - stop_start;
                        chk("event_latency_in_window",
                            32'(lat >= 30 && lat <= 48), 32'h1);
                        if (u_if.rx_valid) begin
                            chk("rx_data", 32'(u_if.rx_data), 32'(e.data));
                            chk("busy_falls_with_valid", 32'(u_if.busy), 32'h0);
                            if (!e.fe) last_good = e.data;
                            valid_times.push_back(cyc);
                        end
                    end
                end
                chk("rx_data_hold", 32'(u_if.rx_data), 32'(last_good));
            end
            prev_v = u_if.rx_valid;
            prev_fe = u_if.framing_error;
        end
    end

    initial begin
        int n;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        wait_ticks(32);

        // clean frame 0xA5
        send_frame(8'hA5, 1'b1);
        wait_ticks(32);
        chk("a5_literal", 32'(u_if.rx_data), 32'hA5);
        chk("a5_idle_busy", 32'(u_if.busy), 32'h0);

        // glitch shorter than half a bit
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        wait_ticks(32);
        chk("glitch_data", 32'(u_if.rx_data), 32'hA5);
        chk("glitch_busy", 32'(u_if.busy), 32'h0);

        // bad stop bit, line held low, then recovery
        send_frame(8'h3C, 1'b0);
        wait_ticks(40);
        chk("break_busy", 32'(u_if.busy), 32'h1);
        chk("break_data", 32'(u_if.rx_data), 32'hA5);
        wait_ticks(40);
        rx = 1'b1;
        wait_ticks(16);
        chk("break_exit_busy", 32'(u_if.busy), 32'h0);
        send_frame(8'h81, 1'b1);
        wait_ticks(32);
        chk("x81_literal", 32'(u_if.rx_data), 32'h81);

        // back-to-back frames, no idle gap
        n = valid_times.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_ticks(32);
        chk("b2b_count", 32'(valid_times.size() - n), 32'd2);
        if (valid_times.size() - n == 2)
            chk("b2b_spacing", 32'(valid_times[n+1] - valid_times[n]),
                32'd640);
        chk("ff_literal", 32'(u_if.rx_data), 32'hFF);

        // reset during bit 4 of an aborted frame
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            rx = 1'(8'h33 >> i);
            wait_ticks(16);
        end
        rx = 1'b1;
        wait_ticks(8);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        wait_ticks(32);
        chk("post_reset_data", 32'(u_if.rx_data), 32'h0);
        send_frame(8'h5A, 1'b1);
        wait_ticks(32);
        chk("x5a_literal", 32'(u_if.rx_data), 32'h5A);

        // sample_pulse gated off mid-frame
        fork
            send_frame(8'hC3, 1'b1);
            begin
                wait_ticks(16 * 3 + 5);
                gate = 1'b0;
                repeat (200) @(negedge clk);
                gate = 1'b1;
            end
        join
        wait_ticks(32);
        chk("c3_literal", 32'(u_if.rx_data), 32'hC3);

        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

16x-oversampling UART receiver, the stage directly downstream of the baud generator. Consumes the generator's one-cycle `sample_pulse` strobe, synchronizes the asynchronous `rx` line, and recovers 8N1 frames. Delivers each received byte with a one-cycle valid strobe and flags frames whose stop bit is low.

## Interface
- `DATA_BITS`, default 8: data bits per frame, LSB first.
- `OVERSAMPLE`, default 16: `sample_pulse` ticks per bit period. Must be an even power of two ≥ 4.
- `clk` input, 1 bit: system clock.
- `reset` input, 1 bit: asynchronous, active-high.
- `sample_pulse` input, 1 bit: one-`clk`-wide oversample strobe from the baud generator.
- `rx` input, 1 bit: asynchronous serial line; idle high.
- `rx_data` output, `DATA_BITS` bits: last good byte. Holds until the next good frame.
- `rx_valid` output, 1 bit: one-cycle pulse; `rx_data` is new.
- `framing_error` output, 1 bit: one-cycle pulse; stop bit sampled low.
- `busy` output, 1 bit: high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized value `rx_s`.
- Counters:
  - `tick`: `$clog2(OVERSAMPLE)` bits.
  - `bitn`: `$clog2(DATA_BITS)` bits.
  - Both advance only on `sample_pulse` cycles. `tick` wraps from `OVERSAMPLE-1` to 0.
- States:
  - IDLE: on `sample_pulse` with `rx_s`=0, go to START with `tick`=0.
  - START: on `sample_pulse`, when `tick`=`OVERSAMPLE/2-1` (mid-bit):
    - `rx_s`=0: go to DATA with `tick`=0 and `bitn`=0.
    - `rx_s`=1: false start; go to IDLE with no output pulses.
  - DATA: on `sample_pulse` with `tick`=`OVERSAMPLE-1`:
    - Shift `rx_s` into the MSB of the shift register (right shift, so LSB arrives first).
    - If `bitn`=`DATA_BITS-1`, go to STOP; otherwise increment `bitn`.
    - Sampling point is one full bit period after mid-start, i.e. mid-bit.
  - STOP: on `sample_pulse` with `tick`=`OVERSAMPLE-1`:
    - `rx_s`=1: load `rx_data` from the shift register, pulse `rx_valid`, go to IDLE.
    - `rx_s`=0: pulse `framing_error`, leave `rx_data` unchanged, go to BREAK.
  - BREAK: on `sample_pulse` with `rx_s`=1, go to IDLE. This prevents a held-low line from retriggering reception.
- `sample_pulse` absent: state, counters, and shift register all hold.
- `rx_valid` and `framing_error` are never high together. Each is high for exactly one `clk`.
- No back-pressure: a consumer that misses a `rx_valid` pulse loses the byte. `rx_data` stays stable until the next good frame.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `framing_error`=0, `busy`=0, state=IDLE, counters=0, synchronizer=1.
- Reset asserted mid-frame: immediate return to IDLE. No partial byte and no pulse is emitted after release.
- Input latency: a change on `rx` reaches `rx_s` after 2 `clk` edges.
- Output latency:
  - `rx_valid` and `framing_error` are registered.
  - They assert in the `clk` cycle after the `sample_pulse` cycle that samples the stop bit.
- `busy`:
  - Rises in the cycle after the START transition.
  - Falls in the same cycle that `rx_valid` rises, or when BREAK exits.
- Back-to-back frames: a new start bit is accepted on the first `sample_pulse` in IDLE. Zero extra idle bits are required beyond the stop bit.
- `sample_pulse` exactly on a state-transition cycle: that tick is consumed by the transition and is not double-counted.

## Structure
- Shared package `uart_pkg`:
  - State enum `rx_state_t`: IDLE, START, DATA, STOP, BREAK.
  - Default constants `UART_DATA_BITS`=8 and `UART_OVERSAMPLE`=16, shared with the baud generator and the future transmitter.
- One sub-module, `sync_2ff`: a 2-flop synchronizer with async reset and a reset-value parameter. It is reused for other asynchronous inputs.

## Test plan
- Bench drives `sample_pulse` every 4 `clk` (one bit = 64 `clk`).
- Scenarios:
  - Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) → single `rx_valid` pulse with `rx_data`=0xA5; `framing_error` stays 0; `busy` low afterwards.
  - Glitch: `rx` low for 16 `clk` (4 ticks), then high → return to IDLE; no pulses; `rx_data` unchanged.
  - Frame 0x3C with stop bit 0, then `rx` held low for 5 bit times, then high → one `framing_error` pulse; `rx_data` keeps its old value; no new frame starts until `rx` goes high. Then send 0x81 → `rx_valid` with 0x81.
  - Back-to-back 0x00 then 0xFF with no idle gap → two `rx_valid` pulses, values 0x00 then 0xFF, spaced 10 bit times apart.
  - `reset` asserted during bit 4 of a frame, then a clean 0x5A → no output from the aborted frame; `rx_valid` with `rx_data`=0x5A; all outputs 0 during reset.
  - `sample_pulse` gated off for 200 `clk` mid-frame, then resumed → frame still decodes correctly once ticks resume.
